// File: rtl/parking_controller.sv
// Parking-lot controller: synchronised entry/exit sensors, occupancy map, door/full timing.
// Optional feature: define PARKING_WAIT_EN to hold a full-lot entry until a bay frees up.
module parking_controller #(
  parameter int SLOTS       = 4,
  parameter int DOOR_CYCLES = 40_000_000,
  localparam int IDX_W      = $clog2(SLOTS),
  localparam int CNT_W      = $clog2(SLOTS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             entry_sensor,
  input  logic             exit_sensor,
  input  logic [IDX_W-1:0] exit_slot,
  output logic [SLOTS-1:0] parking_slots,
  output logic [CNT_W-1:0] capacity,
  output logic [IDX_W-1:0] best_place,
  output logic             best_valid,
  output logic             door_open_light,
  output logic             full_light,
  output logic             exit_err
);

  localparam int DC_W = $clog2(DOOR_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, OPEN_IN, OPEN_OUT, REJECT} state_t;

  state_t           state_q, state_d;
  logic [2:0]       in_sync_q, out_sync_q;
  logic             rise_in_q, rise_out_q;
  logic             pend_in_q, pend_in_d, pend_out_q, pend_out_d;
  logic [IDX_W-1:0] slot_q;
  logic [SLOTS-1:0] occ_q, occ_d;
  logic [DC_W-1:0]  cnt_q, cnt_d;
  logic             err_q, err_d;

  logic             out_rise, out_busy, pend_in_eff, pend_out_eff;
  logic             slot_hit;
  logic [SLOTS-1:0] occ_shift;

  assign out_rise = out_sync_q[1] & ~out_sync_q[2];
  // The captured bay must not be overwritten while an exit is still waiting to be served.
  assign out_busy = pend_out_q | rise_out_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      in_sync_q  <= '0;
      out_sync_q <= '0;
      rise_in_q  <= 1'b0;
      rise_out_q <= 1'b0;
      pend_in_q  <= 1'b0;
      pend_out_q <= 1'b0;
      slot_q     <= '0;
      occ_q      <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_sync_q  <= {in_sync_q[1:0], entry_sensor};
      out_sync_q <= {out_sync_q[1:0], exit_sensor};
      rise_in_q  <= in_sync_q[1] & ~in_sync_q[2];
      rise_out_q <= out_rise & ~out_busy;
      if (out_rise && !out_busy) slot_q <= exit_slot;
      pend_in_q  <= pend_in_d;
      pend_out_q <= pend_out_d;
      occ_q      <= occ_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
    end
  end

  // Fresh edges bypass the pending flags so an idle FSM acts on them immediately.
  assign pend_in_eff  = pend_in_q | rise_in_q;
  assign pend_out_eff = pend_out_q | rise_out_q;
  assign occ_shift    = occ_q >> slot_q;
  assign slot_hit     = ({1'b0, slot_q} < (IDX_W + 1)'(SLOTS)) && occ_shift[0];

  always_comb begin
    state_d    = state_q;
    occ_d      = occ_q;
    cnt_d      = cnt_q;
    pend_in_d  = pend_in_eff;
    pend_out_d = pend_out_eff;
    err_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (pend_out_eff) begin
          pend_out_d = 1'b0;
          if (slot_hit) begin
            occ_d   = occ_q & ~(SLOTS'(1) << slot_q);
            cnt_d   = DC_W'(DOOR_CYCLES);
            state_d = OPEN_OUT;
          end else begin
            err_d = 1'b1;
          end
        end else if (pend_in_eff) begin
          if (best_valid) begin
            pend_in_d = 1'b0;
            occ_d     = occ_q | (SLOTS'(1) << best_place);
            cnt_d     = DC_W'(DOOR_CYCLES);
            state_d   = OPEN_IN;
          end else begin
`ifdef PARKING_WAIT_EN
            pend_in_d = 1'b1;
`else
            pend_in_d = 1'b0;
            cnt_d     = DC_W'(DOOR_CYCLES);
            state_d   = REJECT;
`endif
          end
        end
      end
      default: begin
        cnt_d = cnt_q - DC_W'(1);
        if (cnt_q == DC_W'(1)) state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    best_place = '0;
    capacity   = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (!occ_q[i]) best_place = IDX_W'(i);
    end
    for (int i = 0; i < SLOTS; i++) begin
      capacity = capacity + CNT_W'(!occ_q[i]);
    end
  end

  assign best_valid      = ~&occ_q;
  assign parking_slots   = occ_q;
  assign door_open_light = (state_q == OPEN_IN) || (state_q == OPEN_OUT);
  assign exit_err        = err_q;
`ifdef PARKING_WAIT_EN
  assign full_light = pend_in_q & ~best_valid;
`else
  assign full_light = (state_q == REJECT);
`endif

endmodule
